// File: rtl/lcd_text_writer.sv
// Character-stream front end for the 32-entry LCD text RAM: turns an ASCII
// byte stream into RAM writes with cursor handling and a 32-cycle clear.
module lcd_text_writer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iCHAR_VALID,
  input  logic [7:0] iCHAR,
  output logic       oCHAR_READY,
  input  logic       iCLEAR,
  output logic [4:0] oWADDR,
  output logic [7:0] oWDATA,
  output logic       oWE,
  output logic [4:0] oCURSOR,
  output logic       oBUSY
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] cursor_q, cursor_d;
  logic [4:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       accept;

  assign oCHAR_READY = (state_q == S_IDLE) && !iCLEAR;
  assign accept      = iCHAR_VALID && oCHAR_READY;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    if (iCLEAR) begin
      // A clear request wins over everything, including a running clear.
      state_d  = S_CLEAR;
      cnt_d    = 5'd0;
      cursor_d = 5'd0;
    end else if (state_q == S_CLEAR) begin
      we_d     = 1'b1;
      waddr_d  = cnt_q;
      wdata_d  = FILL_CHAR;
      cnt_d    = cnt_q + 5'd1;
      cursor_d = 5'd0;
      if (cnt_q == 5'd31) state_d = S_IDLE;
    end else if (accept) begin
      if (iCHAR >= 8'h20 && iCHAR <= 8'h7E) begin
        we_d     = 1'b1;
        waddr_d  = cursor_q;
        wdata_d  = iCHAR;
        cursor_d = cursor_q + 5'd1;
      end else begin
        case (iCHAR)
          8'h0A: cursor_d = (cursor_q < 5'd16) ? 5'd16 : 5'd0;
          8'h0D: cursor_d = cursor_q & 5'h10;
          8'h08: begin
            if (cursor_q != 5'd0) begin
              we_d     = 1'b1;
              waddr_d  = cursor_q - 5'd1;
              wdata_d  = FILL_CHAR;
              cursor_d = cursor_q - 5'd1;
            end
          end
          8'h0C: begin
            state_d  = S_CLEAR;
            cnt_d    = 5'd0;
            cursor_d = 5'd0;
          end
          default: ;
        endcase
      end
    end
    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_CLEAR;
      cnt_q    <= 5'd0;
      cursor_q <= 5'd0;
      waddr_q  <= 5'd0;
      wdata_q  <= FILL_CHAR;
      we_q     <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
    end
  end

  assign oWADDR  = waddr_q;
  assign oWDATA  = wdata_q;
  assign oWE     = we_q;
  assign oCURSOR = cursor_q;
  assign oBUSY   = busy_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer: clear sequence, text, control bytes,
// clear request interplay and asynchronous reset.
module tb_lcd_text_writer;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iCHAR_VALID = 1'b0;
  logic [7:0] iCHAR = 8'h00;
  logic       iCLEAR = 1'b0;
  logic       oCHAR_READY;
  logic [4:0] oWADDR;
  logic [7:0] oWDATA;
  logic       oWE;
  logic [4:0] oCURSOR;
  logic       oBUSY;

  int n_chk = 0;
  int n_fail = 0;

  lcd_text_writer #(.FILL_CHAR(8'h20)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iCHAR_VALID(iCHAR_VALID), .iCHAR(iCHAR),
    .oCHAR_READY(oCHAR_READY), .iCLEAR(iCLEAR), .oWADDR(oWADDR),
    .oWDATA(oWDATA), .oWE(oWE), .oCURSOR(oCURSOR), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    chk("ready_before_send", oCHAR_READY, 1);
    iCHAR_VALID = 1'b1;
    iCHAR = c;
    tick();
    iCHAR_VALID = 1'b0;
  endtask

  task automatic write_chk(input string tag, input logic [4:0] a, input logic [7:0] d,
                           input logic [4:0] cur);
    chk({tag, "_we"}, oWE, 1);
    chk({tag, "_addr"}, oWADDR, a);
    chk({tag, "_data"}, oWDATA, d);
    chk({tag, "_cursor"}, oCURSOR, cur);
  endtask

  task automatic nowrite_chk(input string tag, input logic [4:0] cur);
    chk({tag, "_we"}, oWE, 0);
    chk({tag, "_cursor"}, oCURSOR, cur);
  endtask

  // 32 clear writes, addresses 0..31; ready and busy flip only after the last
  task automatic clear_seq(input string tag);
    for (int i = 0; i < 32; i++) begin
      tick();
      write_chk(tag, i[4:0], 8'h20, 5'd0);
      chk({tag, "_busy"}, oBUSY, (i == 31) ? 0 : 1);
      chk({tag, "_ready"}, oCHAR_READY, (i == 31) ? 1 : 0);
    end
  endtask

  initial begin
    #12;
    chk("rst_we", oWE, 0);
    chk("rst_addr", oWADDR, 0);
    chk("rst_data", oWDATA, 8'h20);
    chk("rst_busy", oBUSY, 1);
    chk("rst_ready", oCHAR_READY, 0);
    chk("rst_cursor", oCURSOR, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    clear_seq("boot");
    tick();
    nowrite_chk("idle", 5'd0);

    // "HELLO" back to back
    send(8'h48); write_chk("h0", 5'd0, 8'h48, 5'd1);
    send(8'h45); write_chk("h1", 5'd1, 8'h45, 5'd2);
    send(8'h4C); write_chk("h2", 5'd2, 8'h4C, 5'd3);
    send(8'h4C); write_chk("h3", 5'd3, 8'h4C, 5'd4);
    send(8'h4F); write_chk("h4", 5'd4, 8'h4F, 5'd5);

    // line 1 end, LF from line 2 back to line 1
    for (int i = 5; i < 15; i++) send(8'h2E);
    chk("cur15", oCURSOR, 15);
    send(8'h41); write_chk("A15", 5'd15, 8'h41, 5'd16);
    send(8'h0A); nowrite_chk("lf16", 5'd0);
    send(8'h42); write_chk("B0", 5'd0, 8'h42, 5'd1);
    send(8'h0A); nowrite_chk("lf1", 5'd16);
    for (int i = 16; i < 31; i++) send(8'h2D);
    chk("cur31", oCURSOR, 31);
    send(8'h5A); write_chk("Z31", 5'd31, 8'h5A, 5'd0);

    // CR and backspace
    send(8'h0A); nowrite_chk("lf0", 5'd16);
    send(8'h61); send(8'h62);
    chk("cur18", oCURSOR, 18);
    send(8'h0D); nowrite_chk("cr18", 5'd16);
    send(8'h08); write_chk("bs16", 5'd15, 8'h20, 5'd15);
    send(8'h0D); nowrite_chk("cr15", 5'd0);
    send(8'h08); nowrite_chk("bs0", 5'd0);
    chk("bs0_addr_hold", oWADDR, 15);

    // FF, then iCLEAR at clear step 10 restarts the sequence
    send(8'h63); send(8'h0C);
    nowrite_chk("ff", 5'd0);
    chk("ff_busy", oBUSY, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      write_chk("pre", i[4:0], 8'h20, 5'd0);
    end
    iCLEAR = 1'b1;
    #1;
    chk("clr_ready", oCHAR_READY, 0);
    tick();
    iCLEAR = 1'b0;
    chk("clr_busy", oBUSY, 1);
    clear_seq("restart");

    // iCLEAR with a valid byte in IDLE: byte must not be consumed
    iCHAR_VALID = 1'b1;
    iCHAR = 8'h51;
    iCLEAR = 1'b1;
    #1;
    chk("clrv_ready", oCHAR_READY, 0);
    tick();
    iCHAR_VALID = 1'b0;
    iCLEAR = 1'b0;
    nowrite_chk("clrv", 5'd0);
    chk("clrv_busy", oBUSY, 1);
    clear_seq("clrv");

    // FF at cursor 7, 0x01 held valid until accepted after the clear
    for (int i = 0; i < 7; i++) send(8'h30 + 8'(i));
    chk("cur7", oCURSOR, 7);
    send(8'h0C);
    iCHAR_VALID = 1'b1;
    iCHAR = 8'h01;
    chk("ff7_busy", oBUSY, 1);
    clear_seq("ff7");
    tick();
    iCHAR_VALID = 1'b0;
    nowrite_chk("ctl01", 5'd0);
    send(8'h4B); write_chk("K0", 5'd0, 8'h4B, 5'd1);

    // asynchronous reset mid-operation
    send(8'h4C);
    iRST_N = 1'b0;
    #1;
    chk("arst_we", oWE, 0);
    chk("arst_busy", oBUSY, 1);
    chk("arst_cursor", oCURSOR, 0);
    chk("arst_addr", oWADDR, 0);
    chk("arst_data", oWDATA, 8'h20);
    @(negedge iCLK);
    iRST_N = 1'b1;
    clear_seq("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
